// File: rtl/axi_stream_rx_fifo_pkg.sv
// axi_stream_rx_fifo_pkg: shared helpers and entry layout for the rx fifo
package axi_stream_rx_fifo_pkg;
  `include "axi_stream_defs.vh"
  function automatic int entry_width(input int byte_width);
    return 9 * byte_width + 1;
  endfunction
endpackage

// File: rtl/axi_stream_rx_fifo_if.sv
// axi_stream_rx_fifo_if: AXI-Stream beat channel with source/sink modports
interface axi_stream_rx_fifo_if #(
  parameter int byte_width = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [8*byte_width-1:0] tdata;
  logic [byte_width-1:0]   tkeep;
  logic                    tlast;
  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axi_stream_defs.vh
// axi_stream_defs: shared helpers for stream blocks (popcount, clog2)
`ifndef AXI_STREAM_DEFS_VH
`define AXI_STREAM_DEFS_VH
function automatic int popcount(input logic [63:0] v);
  int n;
  n = 0;
  for (int i = 0; i < 64; i++) n += int'(v[i]);
  return n;
endfunction
function automatic int clog2_f(input int n);
  int r;
  r = 1;
  while ((1 << r) < n) r++;
  return r;
endfunction
`endif

// File: rtl/axi_stream_rx_fifo_mem.sv
// axi_stream_rx_fifo_mem: entry storage, one write port and one async read port
module axi_stream_rx_fifo_mem
  import axi_stream_rx_fifo_pkg::*;
#(
  parameter int width = 37,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [clog2_f(depth)-1:0]  waddr,
  input  logic [width-1:0]           wdata,
  input  logic [clog2_f(depth)-1:0]  raddr,
  output logic [width-1:0]           rdata
);
  logic [width-1:0] mem_q [depth];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/axi_stream_rx_fifo.sv
// axi_stream_rx_fifo: AXI-Stream sink into a show-ahead fifo with stats and sticky protocol checks
module axi_stream_rx_fifo
  import axi_stream_rx_fifo_pkg::*;
#(
  parameter int byte_width  = 4,
  parameter int depth       = 4,
  parameter int count_width = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  axi_stream_rx_fifo_if.slave           s_axis,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [8*byte_width-1:0]       rd_data,
  output logic [byte_width-1:0]         rd_keep,
  output logic                          rd_last,
  output logic [clog2_f(depth+1)-1:0]   level,
  output logic [count_width-1:0]        beat_count,
  output logic [count_width-1:0]        byte_count,
  output logic [count_width-1:0]        packet_count,
  output logic                          err_valid_drop,
  output logic                          err_unstable
);
  localparam int dw = 8 * byte_width;
  localparam int aw = clog2_f(depth);
  localparam int lw = clog2_f(depth + 1);
  localparam int ew = entry_width(byte_width);
  logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [lw-1:0] level_q, level_d;
  logic tready_q, tready_d, push, pop, stall_q, stall_d;
  logic [count_width-1:0] beat_q, beat_d, byte_q, byte_d, pkt_q, pkt_d;
  logic [count_width:0] byte_sum;
  logic [dw-1:0] tdata_q;
  logic [byte_width-1:0] tkeep_q;
  logic tlast_q, drop_q, drop_d, unst_q, unst_d;
  logic [ew-1:0] head;
  always_comb begin
    push     = s_axis.tvalid && tready_q;
    pop      = rd_en && rd_valid;
    wr_d     = wr_q + aw'(push);
    rd_d     = rd_q + aw'(pop);
    level_d  = level_q + lw'(push) - lw'(pop);
    tready_d = level_d < lw'(depth);
    beat_d   = beat_q + count_width'(push && ~&beat_q);
    pkt_d    = pkt_q + count_width'(push && s_axis.tlast && ~&pkt_q);
    byte_sum = {1'b0, byte_q} + (count_width+1)'(push ? popcount(64'(s_axis.tkeep)) : 0);
    byte_d   = byte_sum[count_width] ? '1 : byte_sum[count_width-1:0];
    stall_d  = s_axis.tvalid && !tready_q;
    // stall_q is cleared by reset, so nothing is judged on the first cycle after release
    drop_d   = drop_q || (stall_q && !s_axis.tvalid);
    unst_d   = unst_q || (stall_q && s_axis.tvalid &&
               (s_axis.tdata != tdata_q || s_axis.tkeep != tkeep_q || s_axis.tlast != tlast_q));
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
      beat_q   <= '0;
      byte_q   <= '0;
      pkt_q    <= '0;
      stall_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      drop_q   <= 1'b0;
      unst_q   <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      tready_q <= tready_d;
      beat_q   <= beat_d;
      byte_q   <= byte_d;
      pkt_q    <= pkt_d;
      stall_q  <= stall_d;
      tdata_q  <= s_axis.tdata;
      tkeep_q  <= s_axis.tkeep;
      tlast_q  <= s_axis.tlast;
      drop_q   <= drop_d;
      unst_q   <= unst_d;
    end
  end
  axi_stream_rx_fifo_mem #(.width(ew), .depth(depth)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_q),
    .wdata ({s_axis.tdata, s_axis.tkeep, s_axis.tlast}),
    .raddr (rd_q),
    .rdata (head)
  );
  assign s_axis.tready  = tready_q;
  assign rd_valid       = level_q != '0;
  assign rd_data        = head[ew-1 -: dw];
  assign rd_keep        = head[byte_width:1];
  assign rd_last        = head[0];
  assign level          = level_q;
  assign beat_count     = beat_q;
  assign byte_count     = byte_q;
  assign packet_count   = pkt_q;
  assign err_valid_drop = drop_q;
  assign err_unstable   = unst_q;
endmodule

// File: tb/tb_axi_stream_rx_fifo.sv
// tb_axi_stream_rx_fifo: directed self-checking bench for axi_stream_rx_fifo
module tb_axi_stream_rx_fifo;
  logic clk, resetn, rd_en, rd_valid, rd_last, err_valid_drop, err_unstable;
  logic [31:0] rd_data;
  logic [3:0] rd_keep;
  logic [2:0] level;
  logic [15:0] beat_count, byte_count, packet_count;
  int checks = 0;
  int errors = 0;
  axi_stream_rx_fifo_if #(.byte_width(4)) s_axis ();
  axi_stream_rx_fifo #(.byte_width(4), .depth(4), .count_width(16)) dut (
    .clk(clk), .resetn(resetn), .s_axis(s_axis), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last), .level(level),
    .beat_count(beat_count), .byte_count(byte_count), .packet_count(packet_count),
    .err_valid_drop(err_valid_drop), .err_unstable(err_unstable)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    resetn = 1'b0; rd_en = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0;
    step(); step();
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", s_axis.tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    resetn = 1'b1;
    #1;
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL release_tready_early: got %b expected 0", s_axis.tready); end
    step();
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b expected 1", s_axis.tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL release_level: got %0d expected 0", level); end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'(32'h11 * (i + 1)); s_axis.tkeep = 4'hF; s_axis.tlast = 1'b0;
      step();
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level%0d: got %0d expected %0d", i, level, i + 1); end
      checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL fill_head%0d: got %h expected 00000011", i, rd_data); end
    end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b expected 0", s_axis.tready); end
    s_axis.tdata = 32'h55;
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL held_level: got %0d expected 4", level); end
    checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL held_head: got %h expected 00000011", rd_data); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL held_tready: got %b expected 0", s_axis.tready); end
  endtask
  task automatic test_full_pop();
    logic [31:0] exp [4] = '{32'h22, 32'h33, 32'h44, 32'h55};
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL pop_level: got %0d expected 3", level); end
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL pop_tready: got %b expected 1", s_axis.tready); end
    checks++; if (rd_data !== 32'h22) begin errors++; $display("FAIL pop_head: got %h expected 00000022", rd_data); end
    step();
    s_axis.tvalid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL refill_level: got %0d expected 4", level); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL refill_tready: got %b expected 0", s_axis.tready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp[i]) begin errors++; $display("FAIL drain%0d: got %h expected %h", i, rd_data, exp[i]); end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (beat_count !== 16'd5) begin errors++; $display("FAIL drain_beats: got %0d expected 5", beat_count); end
    checks++; if (byte_count !== 16'd20) begin errors++; $display("FAIL drain_bytes: got %0d expected 20", byte_count); end
    checks++; if (packet_count !== 16'd0) begin errors++; $display("FAIL drain_packets: got %0d expected 0", packet_count); end
  endtask
  task automatic test_back_to_back();
    resetn = 1'b0; step(); resetn = 1'b1; step();
    rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'(256 + i); s_axis.tkeep = 4'hF; s_axis.tlast = (i % 3 == 2);
      if (i > 0) begin
        checks++; if (rd_data !== 32'(255 + i)) begin errors++; $display("FAIL b2b_head%0d: got %h expected %h", i, rd_data, 32'(255 + i)); end
      end
      step();
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level%0d: got %0d expected 1", i, level); end
    end
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    checks++; if (beat_count !== 16'd12) begin errors++; $display("FAIL b2b_beats: got %0d expected 12", beat_count); end
    checks++; if (byte_count !== 16'd48) begin errors++; $display("FAIL b2b_bytes: got %0d expected 48", byte_count); end
    checks++; if (packet_count !== 16'd4) begin errors++; $display("FAIL b2b_packets: got %0d expected 4", packet_count); end
    step();
    rd_en = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_final_level: got %0d expected 0", level); end
  endtask
  task automatic test_protocol_errors();
    checks++; if (err_unstable !== 1'b0 || err_valid_drop !== 1'b0) begin errors++; $display("FAIL err_clean: got %b%b expected 00", err_unstable, err_valid_drop); end
    for (int i = 0; i < 4; i++) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'(i + 1); s_axis.tkeep = 4'hF;
      step();
    end
    s_axis.tdata = 32'hAA;
    step();
    checks++; if (err_unstable !== 1'b0 || err_valid_drop !== 1'b0) begin errors++; $display("FAIL err_stall: got %b%b expected 00", err_unstable, err_valid_drop); end
    s_axis.tdata = 32'hBB;
    step();
    checks++; if (err_unstable !== 1'b1) begin errors++; $display("FAIL err_unstable: got %b expected 1", err_unstable); end
    checks++; if (err_valid_drop !== 1'b0) begin errors++; $display("FAIL err_drop_early: got %b expected 0", err_valid_drop); end
    s_axis.tvalid = 1'b0;
    step();
    checks++; if (err_valid_drop !== 1'b1) begin errors++; $display("FAIL err_drop: got %b expected 1", err_valid_drop); end
    step(); step();
    checks++; if (err_unstable !== 1'b1 || err_valid_drop !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b%b expected 11", err_unstable, err_valid_drop); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL err_level: got %0d expected 4", level); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== 32'(i + 1)) begin errors++; $display("FAIL err_contents%0d: got %h expected %h", i, rd_data, 32'(i + 1)); end
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
  endtask
  task automatic test_reset_mid_packet();
    for (int i = 0; i < 3; i++) begin
      s_axis.tvalid = 1'b1; s_axis.tdata = 32'(192 + i); s_axis.tkeep = 4'hF; s_axis.tlast = 1'b0;
      step();
    end
    s_axis.tvalid = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d expected 3", level); end
    resetn = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_level: got %0d/%b expected 0/0", level, rd_valid); end
    checks++; if (beat_count !== 16'd0 || byte_count !== 16'd0 || packet_count !== 16'd0) begin errors++; $display("FAIL mid_rst_counters: got %0d/%0d/%0d expected 0/0/0", beat_count, byte_count, packet_count); end
    checks++; if (err_unstable !== 1'b0 || err_valid_drop !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b%b expected 00", err_unstable, err_valid_drop); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b expected 0", s_axis.tready); end
    step();
    resetn = 1'b1;
    #1;
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL mid_release_early: got %b expected 0", s_axis.tready); end
    step();
    checks++; if (s_axis.tready !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL mid_release: got %b/%0d expected 1/0", s_axis.tready, level); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_protocol_errors();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_rx_fifo.md
AXI_STREAM_RX_FIFO -- requirements
Module: axi_stream_rx_fifo

Interface
REQ-001 SHALL have parameter byte_width, default 4, TDATA width in bytes (>=1).
REQ-002 SHALL have parameter depth, default 4, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter count_width, default 16, width of statistics counters.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port tvalid  input  1  AXI-Stream slave TVALID.
REQ-007 SHALL have port tready  output  1  AXI-Stream slave TREADY.
REQ-008 SHALL have port tdata  input  8*byte_width  TDATA.
REQ-009 SHALL have port tkeep  input  byte_width  TKEEP.
REQ-010 SHALL have port tlast  input  1  TLAST.
REQ-011 SHALL have port rd_en  input  1  pop request from local consumer.
REQ-012 SHALL have port rd_valid  output  1  head entry present.
REQ-013 SHALL have ports rd_data/rd_keep/rd_last  output  8*byte_width/byte_width/1  head entry fields.
REQ-014 SHALL have port level  output  clog2(depth+1)  occupied entries.
REQ-015 SHALL have ports beat_count, byte_count, packet_count  output  count_width each  statistics.
REQ-016 SHALL have ports err_valid_drop, err_unstable  output  1 each  sticky protocol-error flags.

Function
REQ-017 Handshake SHALL occur in a cycle with tvalid && tready; only then is {tdata,tkeep,tlast} written at tail.
REQ-018 tready SHALL be a register, set to 1 iff level after the current edge < depth; no combinational path from tvalid or rd_en.
REQ-019 Pop SHALL occur when rd_en && rd_valid; rd_en with rd_valid=0 SHALL be ignored, with no state change.
REQ-020 Read port SHALL be show-ahead: rd_valid = (level != 0); rd_data/rd_keep/rd_last = head entry, same cycle, zero latency.
REQ-021 Write-to-read latency SHALL be 1 cycle: a beat accepted at edge N is visible on rd_* after edge N.
REQ-022 Simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo depth.
REQ-023 When full (level=depth), tready=0; a pop in that cycle SHALL raise tready at the next edge, never in the same cycle.
REQ-024 beat_count SHALL +1 per handshake; byte_count SHALL add popcount(tkeep); packet_count SHALL +1 per handshake with tlast=1.
REQ-025 Each counter SHALL saturate at 2^count_width-1 and never wrap.
REQ-026 err_valid_drop SHALL set when tvalid falls after a cycle with tvalid && !tready.
REQ-027 err_unstable SHALL set when tdata, tkeep or tlast changes after a cycle with tvalid && !tready.
REQ-028 Error flags SHALL remain set until reset, and SHALL NOT affect data flow.

Reset
REQ-029 While resetn=0: tready=0, level=0, rd_valid=0, pointers=0, all counters=0, error flags=0.
REQ-030 tready SHALL first rise at the first clk edge with resetn=1, never while resetn=0.
REQ-031 Reset mid-packet SHALL discard all stored entries; rd_data contents are don't-care while rd_valid=0.
REQ-032 Error checks SHALL not evaluate the cycle after reset deassertion, because there is no valid past sample.

Structure
REQ-033 Shared include axi_stream_defs.vh SHALL hold the popcount function and the clog2 helper, for reuse across stream blocks.
REQ-034 Storage SHALL be one sub-module, axi_stream_rx_fifo_mem: depth x (9*byte_width+1) register array with one write port and one async read port.
REQ-035 The block SHALL pass axi_stream_master_monitor-style assumptions on its inputs and assertions on tready when used in formal verification.

Verification (depth=4, byte_width=4, count_width=16)
REQ-036 Reset release, tvalid=0 -> tready=0 during reset; tready=1 one edge after resetn rises; level=0; rd_valid=0.
REQ-037 Push 4 beats 0x11..0x44 with rd_en=0 -> level=4, tready=0 after the 4th edge; a 5th beat is held; rd_data=0x11.
REQ-038 Full, rd_en=1 one cycle while tvalid=1 -> level=3 then tready=1 next edge; the 5th beat is accepted and read order is 0x22,0x33,0x44,0x55.
REQ-039 Continuous push and pop with tkeep=0xF and tlast every 3rd beat, 12 beats -> beat_count=12, byte_count=48, packet_count=4, level constant.
REQ-040 Full, tvalid=1 with tdata changed 0xAA->0xBB, then tvalid dropped -> err_unstable=1 and err_valid_drop=1, both stay set; FIFO contents intact.
REQ-041 Reset asserted with level=3 mid-packet -> level=0, counters=0, flags=0 immediately; tready=0 until the first edge after release.
